// File: rtl/keypad_operand_loader.sv
// 4x4 keypad scanner with tick-based debounce feeding a two-digit dividend/divisor entry FSM.
// Optional feature macro CLEAR_KEY_EN: '*' restarts entry and clears both operands. DEB_TICKS >= 2.
module keypad_operand_loader #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [6:0] op_a,
    output logic [6:0] op_b,
    output logic       op_valid,
    input  logic       op_ack
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W = $clog2(DEB_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(DEB_TICKS);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [3:0]        ROWS_OPEN = 4'b1111;
    localparam logic [3:0]        COL_RESET = 4'b1110;

    // Key codes: 0-9 are the digits themselves, letters and symbols above.
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        SC_SCAN,
        SC_DEBOUNCE,
        SC_RELEASE
    } scan_state_t;

    typedef enum logic [2:0] {
        A_TENS,
        A_UNITS,
        B_TENS,
        B_UNITS,
        WAIT_ACK
    } entry_state_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] column);
        case ({row, column})
            4'b00_00: key_map = 4'd1;
            4'b00_01: key_map = 4'd2;
            4'b00_10: key_map = 4'd3;
            4'b00_11: key_map = KEY_A;
            4'b01_00: key_map = 4'd4;
            4'b01_01: key_map = 4'd5;
            4'b01_10: key_map = 4'd6;
            4'b01_11: key_map = KEY_B;
            4'b10_00: key_map = 4'd7;
            4'b10_01: key_map = 4'd8;
            4'b10_10: key_map = 4'd9;
            4'b10_11: key_map = KEY_C;
            4'b11_00: key_map = KEY_STAR;
            4'b11_01: key_map = 4'd0;
            4'b11_10: key_map = KEY_HASH;
            default:  key_map = KEY_D;
        endcase
    endfunction

    logic [DIV_W-1:0]  r_div_cnt;
    scan_state_t       r_scan_state;
    logic [3:0]        r_col;
    logic [3:0]        r_cap;
    logic [STAB_W-1:0] r_stab;
    logic              r_key_stb;
    logic [3:0]        r_key_code;

    entry_state_t      r_entry_state;
    logic [3:0]        r_tens;
    logic [6:0]        r_op_a;
    logic [6:0]        r_op_b;
    logic              r_op_valid;

    logic              w_tick;
    logic              w_seen;
    logic              w_same;
    logic [STAB_W-1:0] w_stab_inc;
    logic [3:0]        w_rows_low;
    logic              w_single_row;
    logic [1:0]        w_row_idx;
    logic [1:0]        w_col_idx;
    logic [3:0]        w_key_code;
    logic              w_is_digit;
    logic [6:0]        w_operand;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a latch behind.
        w_row_idx = 2'd0;
        w_col_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_cap[i]) w_row_idx = 2'(i);
            if (!r_col[i]) w_col_idx = 2'(i);
        end
        w_key_code   = key_map(w_row_idx, w_col_idx);
        w_rows_low   = ~r_cap;
        w_single_row = (w_rows_low != 4'b0) && ((w_rows_low & (w_rows_low - 4'd1)) == 4'b0);
        w_seen       = (fil != ROWS_OPEN);
        w_same       = (fil == r_cap);
        w_stab_inc   = r_stab + STAB_ONE;
    end

    // fil is read directly: the rows must reflect the column driven since the previous tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_state <= SC_SCAN;
            r_col        <= COL_RESET;
            r_cap        <= ROWS_OPEN;
            r_stab       <= '0;
            r_key_stb    <= 1'b0;
            r_key_code   <= 4'd0;
        end else begin
            r_key_stb <= 1'b0;
            if (w_tick) begin
                case (r_scan_state)
                    SC_SCAN: begin
                        if (w_seen) begin
                            r_cap        <= fil;
                            r_stab       <= STAB_ONE;
                            r_scan_state <= SC_DEBOUNCE;
                        end else begin
                            r_col <= {r_col[2:0], r_col[3]};
                        end
                    end
                    SC_DEBOUNCE: begin
                        if (!w_seen) begin
                            r_stab       <= '0;
                            r_scan_state <= SC_SCAN;
                        end else if (!w_same) begin
                            r_cap  <= fil;
                            r_stab <= STAB_ONE;
                        end else if (w_stab_inc == STAB_DONE) begin
                            // A multi-row chord is debounced like a key but never delivered.
                            r_key_stb    <= w_single_row;
                            r_key_code   <= w_key_code;
                            r_stab       <= '0;
                            r_scan_state <= SC_RELEASE;
                        end else begin
                            r_stab <= w_stab_inc;
                        end
                    end
                    SC_RELEASE: begin
                        if (w_seen) begin
                            r_stab <= '0;
                        end else if (w_stab_inc == STAB_DONE) begin
                            r_stab       <= '0;
                            r_scan_state <= SC_SCAN;
                        end else begin
                            r_stab <= w_stab_inc;
                        end
                    end
                    default: begin
                        r_stab       <= '0;
                        r_scan_state <= SC_SCAN;
                    end
                endcase
            end
        end
    end

    assign w_is_digit = (r_key_code <= 4'd9);
    assign w_operand  = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, r_key_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry_state <= A_TENS;
            r_tens        <= 4'd0;
            r_op_a        <= 7'd0;
            r_op_b        <= 7'd0;
            r_op_valid    <= 1'b0;
        end else begin
            case (r_entry_state)
                WAIT_ACK: begin
                    if (op_ack) begin
                        r_op_valid    <= 1'b0;
                        r_entry_state <= A_TENS;
                    end
                end
                default: begin
                    if (r_key_stb) begin
                        if (w_is_digit) begin
                            case (r_entry_state)
                                A_TENS: begin
                                    r_tens        <= r_key_code;
                                    r_entry_state <= A_UNITS;
                                end
                                A_UNITS: begin
                                    r_op_a        <= w_operand;
                                    r_entry_state <= B_TENS;
                                end
                                B_TENS: begin
                                    r_tens        <= r_key_code;
                                    r_entry_state <= B_UNITS;
                                end
                                B_UNITS: begin
                                    r_op_b        <= w_operand;
                                    r_op_valid    <= 1'b1;
                                    r_entry_state <= WAIT_ACK;
                                end
                                default: r_entry_state <= A_TENS;
                            endcase
                        end
`ifdef CLEAR_KEY_EN
                        else if (r_key_code == KEY_STAR) begin
                            r_op_a        <= 7'd0;
                            r_op_b        <= 7'd0;
                            r_entry_state <= A_TENS;
                        end
`else
`endif
                    end
                end
            endcase
        end
    end

    assign col      = r_col;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;

endmodule
